// File: rtl/serial_rx_if.sv
// Receiver-side signal bundle for serial_rx: the serial line in, decoded byte and status out.
// The parity_err member exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;

    modport master (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy,
        output parity_err
    );

    modport slave (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy,
        input  parity_err
    );
`else
    modport master (
        input  rx_in,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
`endif
endinterface

// File: rtl/serial_rx.sv
// UART receiver, 8N1, LSB first, centre-sampled from the start-bit edge.
// Optional macro SERIAL_RX_PARITY_EN adds an even-parity bit between D7 and stop (8E1).
module serial_rx #(
    parameter int CLK_HZ = 54000000,
    parameter int BAUD   = 9600
) (
    input  logic         clk,
    input  logic         reset,
    serial_rx_if.master  bus
);

    localparam int          BIT_CNT   = CLK_HZ / BAUD;
    localparam int          HALF      = BIT_CNT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(BIT_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

`ifdef SERIAL_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic        rx_meta_r;
    logic        rx_s_r;
    logic        rx_d_r;
    state_t      state_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        frame_err_r;
    logic        busy_r;
`ifdef SERIAL_RX_PARITY_EN
    logic        parity_bit_r;
    logic        parity_err_r;
`endif

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
            rx_d_r    <= 1'b1;
        end else begin
            rx_meta_r <= bus.rx_in;
            rx_s_r    <= rx_meta_r;
            rx_d_r    <= rx_s_r;
        end
    end

    // Frame FSM with registered outputs; busy tracks state != IDLE exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 16'd0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            rx_data_r    <= 8'd0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bit_r <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= 16'd0;
                    // Only a fresh high-to-low transition starts a frame, so a stuck-low line is ignored.
                    if (rx_d_r && !rx_s_r) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end

                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= 16'd0;
                        if (rx_s_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

                DATA: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r     <= 16'd0;
                        shift_r   <= {rx_s_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r        <= 16'd0;
                        parity_bit_r <= rx_s_r;
                        state_r      <= STOP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
`endif

                STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                    if (cnt_r == BIT_LAST) begin
                        cnt_r   <= 16'd0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (rx_s_r) begin
                            rx_data_r   <= shift_r;
                            rx_valid_r  <= 1'b1;
                            frame_err_r <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
`ifdef SERIAL_RX_PARITY_EN
                        parity_err_r <= even_parity(shift_r) ^ parity_bit_r;
`endif
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 16'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule
